// File: rtl/digit_encode_hlsm.sv
// Purpose: scans a DEPTH-entry register file and rewrites every entry holding 0..9 as its ASCII digit.
// Latency: FIN entered 66+N edges after go is sampled (DEPTH=16, N = entries converted); done pulses for one cycle.
// Backpressure: none; go is only looked at in IDLE, and the register file must answer reads combinationally.
module digit_encode_hlsm #(
    parameter int BASE  = 48,
    parameter int DEPTH = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       go,
    output logic       R_en,
    output logic [3:0] R_Addr,
    input  logic [7:0] R_Data,
    output logic       W_en,
    output logic [3:0] W_Addr,
    output logic [7:0] W_Data,
    output logic [4:0] count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CHECK,
        S_READ,
        S_TEST,
        S_WRITE,
        S_NEXT,
        S_FIN
    } state_t;

    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    localparam logic [7:0] BASE_L  = 8'(BASE);
    localparam logic [7:0] MAX_DIG = 8'd9;

    state_t     state;
    logic [4:0] i;
    logic [7:0] temp;

    // State walk plus registered Moore outputs: each output register is loaded with
    // the value belonging to the state being entered, so it is valid for that whole state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= S_IDLE;
            i      <= '0;
            temp   <= '0;
            count  <= '0;
            R_en   <= 1'b0;
            R_Addr <= '0;
            W_en   <= 1'b0;
            W_Addr <= '0;
            W_Data <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            R_en   <= 1'b0;
            R_Addr <= '0;
            W_en   <= 1'b0;
            W_Addr <= '0;
            W_Data <= '0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_INIT;
                        busy  <= 1'b1;
                    end
                end
                S_INIT: begin
                    i     <= '0;
                    count <= '0;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (i < DEPTH_L) begin
                        state  <= S_READ;
                        R_en   <= 1'b1;
                        R_Addr <= i[3:0];
                    end else begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
                end
                S_READ: begin
                    temp  <= R_Data;
                    state <= S_TEST;
                end
                S_TEST: begin
                    // Anything above 9 (including existing ASCII digits) is left alone.
                    if (temp <= MAX_DIG) begin
                        state  <= S_WRITE;
                        W_en   <= 1'b1;
                        W_Addr <= i[3:0];
                        W_Data <= temp + BASE_L;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    count <= count + 5'd1;
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    i     <= i + 5'd1;
                    state <= S_CHECK;
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
